modulador_ctrl: RTL and testbench

MODULADOR_CTRL -- requirements
Module: modulador_ctrl

---
 rtl/modulador_ctrl.sv | 149 ++++++++++++++
 tb/tb_modulador_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/modulador_ctrl.sv
// Frame sequencer for a byte modulator: payload FIFO, then preamble/sync/payload framing on DADO.
// Optional trailing XOR checksum byte is enabled by defining MODULADOR_CTRL_CKSUM_EN.
module modulador_ctrl #(
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned PREAMBLE_LEN  = 2,
   parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
   parameter logic [7:0]  SYNC_BYTE     = 8'hD3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   input  logic       frame_start,
   input  logic       byte_done,
   output logic [7:0] DADO,
   output logic       tx_en,
   output logic       busy,
   output logic [2:0] dbg_state_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [3:0] PRE_LAST_C = 4'(PREAMBLE_LEN - 1);

`ifdef MODULADOR_CTRL_CKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SYNC, S_PAYLOAD, S_CKSUM} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SYNC, S_PAYLOAD} state_t;
`endif

   // Handshake: a byte is taken on a rising edge when din_valid and din_ready are both high;
   // din_ready depends only on the registered fill level, so a full FIFO drops the byte even
   // if a pop happens on that same edge.
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   state_t        state_q;
   logic [7:0]    dado_q;
   logic          tx_en_q, busy_q;
   logic [3:0]    pre_cnt_q;
`ifdef MODULADOR_CTRL_CKSUM_EN
   logic [7:0]    cksum_q;
`endif

   logic       push, pop, has_data;
   logic [7:0] head;

   assign has_data  = (count_q != '0);
   assign din_ready = (count_q != FULL_C);
   assign push      = din_valid && din_ready;
   assign pop       = byte_done && has_data && ((state_q == S_SYNC) || (state_q == S_PAYLOAD));
   assign head      = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         dado_q    <= 8'h00;
         tx_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         pre_cnt_q <= '0;
`ifdef MODULADOR_CTRL_CKSUM_EN
         cksum_q   <= 8'h00;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (frame_start && has_data) begin
                  state_q   <= S_PREAMBLE;
                  dado_q    <= PREAMBLE_BYTE;
                  tx_en_q   <= 1'b1;
                  busy_q    <= 1'b1;
                  pre_cnt_q <= '0;
`ifdef MODULADOR_CTRL_CKSUM_EN
                  cksum_q   <= 8'h00;
`endif
               end
            end
            S_PREAMBLE: begin
               if (byte_done) begin
                  pre_cnt_q <= pre_cnt_q + 4'd1;
                  if (pre_cnt_q == PRE_LAST_C) begin
                     state_q <= S_SYNC;
                     dado_q  <= SYNC_BYTE;
                  end
               end
            end
            S_SYNC, S_PAYLOAD: begin
               if (byte_done) begin
                  if (has_data) begin
                     state_q <= S_PAYLOAD;
                     dado_q  <= head;
`ifdef MODULADOR_CTRL_CKSUM_EN
                     cksum_q <= cksum_q ^ head;
`endif
                  end else begin
`ifdef MODULADOR_CTRL_CKSUM_EN
                     state_q <= S_CKSUM;
                     dado_q  <= cksum_q;
`else
                     // DADO keeps the last payload byte after the frame closes.
                     state_q <= S_IDLE;
                     tx_en_q <= 1'b0;
                     busy_q  <= 1'b0;
`endif
                  end
               end
            end
`ifdef MODULADOR_CTRL_CKSUM_EN
            S_CKSUM: begin
               if (byte_done) begin
                  state_q <= S_IDLE;
                  tx_en_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign DADO        = dado_q;
   assign tx_en       = tx_en_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_modulador_ctrl.sv
// Bench for modulador_ctrl: frame contents modelled as header list + payload queue (+ XOR byte),
// expected outputs queued by the driver and compared by an independent monitor.
module tb_modulador_ctrl;

   localparam int         DEPTH = 4;
   localparam int         PL    = 2;
   localparam logic [7:0] PRE   = 8'h55;
   localparam logic [7:0] SYN   = 8'hD3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       frame_start = 1'b0;
   logic       byte_done = 1'b0;
   logic       din_ready;
   logic [7:0] DADO;
   logic       tx_en, busy;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   modulador_ctrl #(.DEPTH(DEPTH), .PREAMBLE_LEN(PL), .PREAMBLE_BYTE(PRE), .SYNC_BYTE(SYN)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .frame_start(frame_start), .byte_done(byte_done), .DADO(DADO), .tx_en(tx_en),
      .busy(busy), .dbg_state_o(dbg_state)
   );

   // Scoreboard: one expected {tx_en, busy, DADO} per edge that saw frame_start or byte_done.
   logic [9:0] exp_q[$];
   logic [7:0] mq[$];
   logic [7:0] pend[$];
   int         checks = 0;
   int         errors = 0;
   bit         m_act = 0, m_tail = 0, m_cks_done = 0;
   logic [7:0] m_dado = 8'h00, m_x = 8'h00;
   bit         ev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ev <= 1'b0;
      else        ev <= frame_start | byte_done;
   end

   always @(negedge clk) begin
      if (ev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL monitor_underflow: output event with no expected value at %0t", $time);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            check("frame_out", {22'd0, tx_en, busy, DADO}, {22'd0, e});
         end
      end
   end

   // Reference model: frame = PL preamble bytes, sync byte, every byte in the FIFO when its turn
   // comes, then optionally the XOR of those payload bytes.
   task automatic model_step(input bit v, input logic [7:0] d, input bit fs, input bit bd);
      bit acc;
      acc = v && (mq.size() < DEPTH);
      if (fs || bd) begin
         if (!m_act) begin
            if (fs && mq.size() >= 1) begin
               m_act = 1; m_tail = 0; m_cks_done = 0; m_x = 8'h00; m_dado = PRE;
               pend.delete();
               for (int i = 0; i < PL - 1; i++) pend.push_back(PRE);
               pend.push_back(SYN);
            end
         end else if (bd) begin
            if (pend.size() != 0) begin
               m_dado = pend.pop_front();
            end else if (!m_tail && mq.size() != 0) begin
               m_dado = mq.pop_front();
               m_x    = m_x ^ m_dado;
            end else begin
               m_tail = 1;
`ifdef MODULADOR_CTRL_CKSUM_EN
               if (!m_cks_done) begin
                  m_dado = m_x;
                  m_cks_done = 1;
               end else begin
                  m_act = 0;
               end
`else
               m_act = 0;
`endif
            end
         end
         exp_q.push_back({m_act, m_act, m_dado});
      end
      if (acc) mq.push_back(d);
   endtask

   task automatic cyc(input bit v, input logic [7:0] d, input bit fs, input bit bd);
      @(negedge clk);
      check("din_ready", {31'd0, din_ready}, {31'd0, (mq.size() != DEPTH)});
      din_valid = v; din = d; frame_start = fs; byte_done = bd;
      model_step(v, d, fs, bd);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
   endtask

   task automatic run_frame(input bit mid_fs);
      cyc(0, 8'h00, 1, 0);
      for (int k = 0; k < 64 && m_act; k++) begin
         cyc(0, 8'h00, mid_fs && (k % 2 == 0), 0);
         cyc(0, 8'h00, 0, 1);
      end
      if (m_act) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout: frame still active after 64 byte_done pulses");
      end
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_dado",  {24'd0, DADO}, 32'h00);
      check("rst_tx_en", {31'd0, tx_en}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, din_ready}, 32'd1);
      mq.delete(); pend.delete(); exp_q.delete();
      m_act = 0; m_tail = 0; m_cks_done = 0; m_dado = 8'h00; m_x = 8'h00;
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #1;
      check("rst0_dado",  {24'd0, DADO}, 32'h00);
      check("rst0_tx_en", {31'd0, tx_en}, 32'd0);
      check("rst0_busy",  {31'd0, busy}, 32'd0);
      check("rst0_ready", {31'd0, din_ready}, 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // single byte frame, byte_done every 256 cycles
      cyc(1, 8'hA1, 0, 0);
      cyc(0, 8'h00, 1, 0);
      for (int k = 0; k < 5; k++) begin
         idle(255);
         cyc(0, 8'h00, 0, 1);
      end
      idle(1);
      #1 check("tx_en_after_frame", {31'd0, tx_en}, 32'd0);

      // overfill: fifth byte dropped, frame then carries four bytes
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'h10 + i), 0, 0);
      idle(1);
      run_frame(0);

      // checksum pattern 12,34,0F
      cyc(1, 8'h12, 0, 0); cyc(1, 8'h34, 0, 0); cyc(1, 8'h0F, 0, 0);
      run_frame(0);

      // frame_start with empty FIFO, then frame_start pulses mid-frame
      cyc(0, 8'h00, 1, 0);
      idle(1);
      #1 check("empty_start_busy", {31'd0, busy}, 32'd0);
      cyc(1, 8'hC4, 0, 0); cyc(1, 8'h7E, 0, 0);
      run_frame(1);

      // full FIFO during payload: simultaneous push and pop
      for (int i = 0; i < 4; i++) cyc(1, 8'(8'hB0 + i), 0, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 1); cyc(0, 8'h00, 0, 1); cyc(0, 8'h00, 0, 1);
      cyc(1, 8'hE4, 0, 0);
      cyc(1, 8'hEE, 0, 1);
      run_frame(0);

      // reset while in SYNC with queued bytes
      cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0); cyc(1, 8'h03, 0, 0);
      cyc(0, 8'h00, 1, 0);
      cyc(0, 8'h00, 0, 1); cyc(0, 8'h00, 0, 1);
      idle(1);
      apply_reset();
      cyc(1, 8'h9A, 0, 0); cyc(1, 8'h6B, 0, 0);
      run_frame(0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 15) == 0,
             $urandom_range(0, 2) == 0);
      end
      idle(3);
      check("exp_q_drain", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
